// File: rtl/hangman_letter_entry.sv
// Player-input front end for the hangman controller: debounced buttons, letter scroll, command emit.
// Optional repeat-guess rejection is enabled by defining HANGMAN_USED_MASK_EN.
module hangman_letter_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic       i_btn_select,
  input  logic       i_btn_new,
  input  logic       i_ready,
  output logic [5:0] o_chip_input,
  output logic [4:0] o_cur_letter,
  output logic       o_pending,
  output logic       o_used_hit
);

  localparam logic [15:0] LP_DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [5:0]  LP_CMD_START = 6'b111111;
  localparam logic [5:0]  LP_CMD_NEW   = 6'b100000;
  localparam int unsigned LP_UP  = 0;
  localparam int unsigned LP_DN  = 1;
  localparam int unsigned LP_SEL = 2;
  localparam int unsigned LP_NEW = 3;

  typedef enum logic [1:0] {StStart, StEntry, StEmit} state_e;

  // Reset: asserts immediately, releases two edges after the pin goes high.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  logic [3:0]  w_raw;
  logic [3:0]  r_sync1;
  logic [3:0]  r_sync2;
  logic [3:0]  r_db;
  logic [3:0]  r_db_prev;
  logic [15:0] r_cnt [4];
  logic [3:0]  w_ev;

  assign w_raw = {i_btn_new, i_btn_select, i_btn_down, i_btn_up};

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_db      <= '0;
      r_db_prev <= '0;
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1   <= w_raw;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == LP_DB_LAST) begin
          r_db[i]  <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 16'd1;
        end
      end
    end
  end

  assign w_ev = r_db & ~r_db_prev;

  state_e     r_state;
  state_e     w_state_d;
  state_e     r_ret;
  state_e     w_ret_d;
  logic [5:0] r_cmd;
  logic [5:0] w_cmd_d;
  logic [5:0] r_chip;
  logic [5:0] w_chip_d;
  logic [4:0] r_letter;
  logic [4:0] w_letter_d;
  logic       r_pending;
  logic       w_pending_d;
  logic       w_scroll;

`ifdef HANGMAN_USED_MASK_EN
  logic [25:0] r_mask;
  logic [25:0] w_mask_d;
  logic [4:0]  w_cur_idx;
  logic [4:0]  w_emit_idx;
  logic        w_used;
  logic        r_used_hit;
  logic        w_used_hit_d;

  assign w_cur_idx  = r_letter - 5'd1;
  assign w_emit_idx = r_cmd[4:0] - 5'd1;
  assign w_used     = r_mask[w_cur_idx];
`endif

  always_comb begin
    w_state_d   = r_state;
    w_ret_d     = r_ret;
    w_cmd_d     = r_cmd;
    w_chip_d    = 6'b000000;
    w_pending_d = r_pending;
    w_scroll    = 1'b1;
`ifdef HANGMAN_USED_MASK_EN
    w_mask_d     = r_mask;
    w_used_hit_d = 1'b0;
`endif
    unique case (r_state)
      StStart: begin
        if (w_ev[LP_SEL]) begin
          w_cmd_d     = LP_CMD_START;
          w_ret_d     = StEntry;
          w_state_d   = StEmit;
          w_pending_d = 1'b1;
          w_scroll    = 1'b0;
        end
      end
      StEntry: begin
        if (w_ev[LP_NEW]) begin
          w_cmd_d     = LP_CMD_NEW;
          w_ret_d     = StStart;
          w_state_d   = StEmit;
          w_pending_d = 1'b1;
          w_scroll    = 1'b0;
        end else if (w_ev[LP_SEL]) begin
          w_scroll = 1'b0;
`ifdef HANGMAN_USED_MASK_EN
          if (w_used) begin
            w_used_hit_d = 1'b1;
          end else begin
            w_cmd_d     = {1'b1, r_letter};
            w_ret_d     = StEntry;
            w_state_d   = StEmit;
            w_pending_d = 1'b1;
          end
`else
          w_cmd_d     = {1'b1, r_letter};
          w_ret_d     = StEntry;
          w_state_d   = StEmit;
          w_pending_d = 1'b1;
`endif
        end
      end
      StEmit: begin
        if (i_ready) begin
          w_chip_d    = r_cmd;
          w_pending_d = 1'b0;
          w_state_d   = r_ret;
`ifdef HANGMAN_USED_MASK_EN
          if (r_cmd == LP_CMD_START) begin
            w_mask_d = '0;
          end else if (r_cmd != LP_CMD_NEW) begin
            w_mask_d[w_emit_idx] = 1'b1;
          end
`endif
        end
      end
      default: begin
        w_state_d = StStart;
      end
    endcase
  end

  // Simultaneous up and down cancel; wrap keeps the letter inside 1..26.
  always_comb begin
    w_letter_d = r_letter;
    if (w_scroll && (w_ev[LP_UP] ^ w_ev[LP_DN])) begin
      if (w_ev[LP_UP]) begin
        w_letter_d = (r_letter >= 5'd26) ? 5'd1 : r_letter + 5'd1;
      end else begin
        w_letter_d = (r_letter <= 5'd1) ? 5'd26 : r_letter - 5'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state   <= StStart;
      r_ret     <= StEntry;
      r_cmd     <= 6'b000000;
      r_chip    <= 6'b000000;
      r_letter  <= 5'd1;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_ret     <= w_ret_d;
      r_cmd     <= w_cmd_d;
      r_chip    <= w_chip_d;
      r_letter  <= w_letter_d;
      r_pending <= w_pending_d;
    end
  end

`ifdef HANGMAN_USED_MASK_EN
  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_mask     <= '0;
      r_used_hit <= 1'b0;
    end else begin
      r_mask     <= w_mask_d;
      r_used_hit <= w_used_hit_d;
    end
  end

  assign o_used_hit = r_used_hit;
`else
  assign o_used_hit = 1'b0;
`endif

  assign o_chip_input = r_chip;
  assign o_cur_letter = r_letter;
  assign o_pending    = r_pending;

endmodule

// File: tb/tb_hangman_letter_entry.sv
// Directed bench for hangman_letter_entry (DEBOUNCE_CYCLES = 4); expectations adapt to
// HANGMAN_USED_MASK_EN.
module tb_hangman_letter_entry;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn;    // {new, select, down, up}
  logic       ready;
  logic [5:0] chip_input;
  logic [4:0] cur_letter;
  logic       pending;
  logic       used_hit;

  int tests;
  int fails;

  int          n_cmd;
  logic [5:0]  cmd_val;
  int          cmd_at;
  int          pend_at;
  int          let_at;
  int          hits;

  localparam logic [3:0] B_UP  = 4'b0001;
  localparam logic [3:0] B_DN  = 4'b0010;
  localparam logic [3:0] B_SEL = 4'b0100;
  localparam logic [3:0] B_NEW = 4'b1000;

  hangman_letter_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_btn_up     (btn[0]),
    .i_btn_down   (btn[1]),
    .i_btn_select (btn[2]),
    .i_btn_new    (btn[3]),
    .i_ready      (ready),
    .o_chip_input (chip_input),
    .o_cur_letter (cur_letter),
    .o_pending    (pending),
    .o_used_hit   (used_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raise the masked buttons for 'hold' sampled edges, observe 'window' edges.
  // Times are recorded as edges after the first edge that sampled the press.
  task automatic do_press(input logic [3:0] mask, input int hold, input int window);
    logic [4:0] l0;
    l0      = cur_letter;
    n_cmd   = 0;
    cmd_val = '0;
    cmd_at  = -1;
    pend_at = -1;
    let_at  = -1;
    hits    = 0;
    btn     = btn | mask;
    for (int t = 1; t <= window; t++) begin
      @(posedge clk);
      #1;
      if (t == hold) btn = btn & ~mask;
      if (chip_input != 6'd0) begin
        n_cmd++;
        if (cmd_at < 0) begin
          cmd_at  = t - 1;
          cmd_val = chip_input;
        end
      end
      if (pending && pend_at < 0) pend_at = t - 1;
      if (cur_letter != l0 && let_at < 0) let_at = t - 1;
      if (used_hit) hits++;
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    btn   = 4'b0000;
    ready = 1'b1;
    rst_n = 1'b0;
    tick(3);
    chk("rst_chip", 32'(chip_input), 0);
    chk("rst_letter", 32'(cur_letter), 1);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_used_hit", 32'(used_hit), 0);
    rst_n = 1'b1;
    tick(5);

    // Start command: one cycle, seven edges after the press is first sampled.
    do_press(B_SEL, 6, 20);
    chk("start_count", n_cmd, 1);
    chk("start_code", 32'(cmd_val), 32'h3F);
    chk("start_latency", cmd_at, 7);
    chk("start_pend_latency", pend_at, 6);

    do_press(B_UP, 6, 20);
    chk("up_latency", let_at, 6);
    chk("up_no_cmd", n_cmd, 0);
    for (int i = 0; i < 12; i++) do_press(B_UP, 6, 20);
    chk("up13_letter", 32'(cur_letter), 14);

    do_press(B_SEL, 6, 20);
    chk("guess_n_count", n_cmd, 1);
    chk("guess_n_code", 32'(cmd_val), 32'h2E);

    for (int i = 0; i < 12; i++) do_press(B_UP, 6, 20);
    chk("letter_26", 32'(cur_letter), 26);
    do_press(B_UP, 6, 20);
    chk("wrap_up_26_to_1", 32'(cur_letter), 1);
    do_press(B_DN, 6, 20);
    chk("wrap_down_1_to_26", 32'(cur_letter), 26);
    do_press(B_UP, 6, 20);
    chk("back_to_1", 32'(cur_letter), 1);

    do_press(B_UP, 3, 20);
    chk("glitch3_letter", 32'(cur_letter), 1);
    do_press(B_UP, 4, 20);
    chk("stable4_letter", 32'(cur_letter), 2);
    do_press(B_UP, 100, 120);
    chk("hold100_letter", 32'(cur_letter), 3);

    do_press(B_UP | B_DN, 6, 20);
    chk("up_down_cancel", 32'(cur_letter), 3);

    // Stalled emission: letter 3 is latched while ready is low.
    ready = 1'b0;
    do_press(B_SEL, 6, 20);
    chk("stall_no_emit", n_cmd, 0);
    chk("stall_pend_latency", pend_at, 6);
    do_press(B_UP, 6, 20);
    do_press(B_UP, 6, 20);
    chk("stall_scroll_letter", 32'(cur_letter), 5);
    chk("stall_pending", 32'(pending), 1);
    chk("stall_no_emit2", n_cmd, 0);
    do_press(B_SEL, 6, 20);
    chk("stall_sel_dropped", n_cmd, 0);
    ready = 1'b1;
    do_press(4'b0000, 1, 10);
    chk("release_count", n_cmd, 1);
    chk("release_code", 32'(cmd_val), 32'h23);
    chk("release_pending", 32'(pending), 0);

    // New and select together: new wins, back in START.
    do_press(B_NEW | B_SEL, 6, 20);
    chk("newsel_count", n_cmd, 1);
    chk("newsel_code", 32'(cmd_val), 32'h20);
    do_press(B_NEW, 6, 20);
    chk("new_in_start_ignored", n_cmd, 0);
    do_press(B_SEL, 6, 20);
    chk("restart_code", 32'(cmd_val), 32'h3F);
    chk("restart_count", n_cmd, 1);

    do_press(B_SEL, 6, 20);
    chk("guess_e_code", 32'(cmd_val), 32'h25);
    chk("guess_e_hits", hits, 0);
    do_press(B_SEL, 6, 20);
`ifdef HANGMAN_USED_MASK_EN
    chk("repeat_e_count", n_cmd, 0);
    chk("repeat_e_hits", hits, 1);
    chk("repeat_e_pending", pend_at, -1);
`else
    chk("repeat_e_count", n_cmd, 1);
    chk("repeat_e_code", 32'(cmd_val), 32'h25);
    chk("repeat_e_hits", hits, 0);
`endif
    do_press(B_NEW, 6, 20);
    chk("new2_code", 32'(cmd_val), 32'h20);
    do_press(B_SEL, 6, 20);
    chk("start2_code", 32'(cmd_val), 32'h3F);
    do_press(B_SEL, 6, 20);
    chk("e_after_new_count", n_cmd, 1);
    chk("e_after_new_code", 32'(cmd_val), 32'h25);

    // Reset during EMIT discards the latched command.
    ready = 1'b0;
    do_press(B_SEL, 6, 20);
    chk("pre_reset_pending", 32'(pending), 1);
    rst_n = 1'b0;
    #2;
    chk("mid_reset_pending", 32'(pending), 0);
    chk("mid_reset_letter", 32'(cur_letter), 1);
    tick(2);
    rst_n = 1'b1;
    ready = 1'b1;
    do_press(4'b0000, 1, 20);
    chk("post_reset_no_emit", n_cmd, 0);
    chk("post_reset_pending", 32'(pending), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
